// File: rtl/port_demux_ser_if.sv
// rtl/port_demux_ser_if.sv - serial frame input and routed port outputs of port_demux_ser
// master drives the serial side, slave is the demultiplexer.
interface port_demux_ser_if #(
   parameter int NUM_PORTS = 4,
   parameter int PORT_BITS = 2,
   parameter int LEN_BITS  = 4
);
   logic                 clkEn;
   logic                 serIn;
   logic [NUM_PORTS-1:0] pout;
   logic [NUM_PORTS-1:0] pval;
   logic [PORT_BITS-1:0] portNum;
   logic [LEN_BITS-1:0]  remain;
   logic                 busy;
   logic                 done;
   logic                 perr;

   modport master (
      output clkEn, serIn,
      input  pout, pval, portNum, remain, busy, done, perr
   );

   modport slave (
      input  clkEn, serIn,
      output pout, pval, portNum, remain, busy, done, perr
   );
endinterface

// File: rtl/port_demux_ser.sv
// rtl/port_demux_ser.sv - serial frame to N-port demultiplexer with control FSM
// Optional even-parity trailer bit enabled by macro PORT_DEMUX_PARITY_EN.
module port_demux_ser #(
   parameter int NUM_PORTS = 4,
   parameter int PORT_BITS = 2,
   parameter int LEN_BITS  = 4
) (
   input  logic           clk,
   input  logic           rst,
   port_demux_ser_if.slave bus
);
   localparam int CNT_MAX = (PORT_BITS > LEN_BITS) ? PORT_BITS : LEN_BITS;
   localparam int CW      = $clog2(CNT_MAX + 1);

`ifdef PORT_DEMUX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_PORT, S_LEN, S_DATA, S_PAR, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_PORT, S_LEN, S_DATA, S_DONE} state_t;
`endif

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [PORT_BITS-1:0] port_q;
   logic [LEN_BITS-1:0]  remain_q;
   logic                 busy_q;
   logic                 done_q;
   logic [PORT_BITS-1:0] port_shift;
   logic [LEN_BITS-1:0]  len_shift;

`ifdef PORT_DEMUX_PARITY_EN
   logic                 par_acc;
   logic                 perr_q;
`endif

   // MSB-first shift of the field registers, written width-agnostic for 1-bit fields
   assign port_shift = PORT_BITS'({port_q, bus.serIn});
   assign len_shift  = LEN_BITS'({remain_q, bus.serIn});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         port_q   <= '0;
         remain_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef PORT_DEMUX_PARITY_EN
         par_acc  <= 1'b0;
         perr_q   <= 1'b0;
`endif
      end else if (bus.clkEn) begin
         unique case (state)
            S_IDLE: begin
               if (!bus.serIn) begin
                  state  <= S_PORT;
                  cnt    <= '0;
                  busy_q <= 1'b1;
`ifdef PORT_DEMUX_PARITY_EN
                  par_acc <= 1'b0;
                  perr_q  <= 1'b0;
`endif
               end
            end
            S_PORT: begin
               port_q <= port_shift;
               if (cnt == CW'(PORT_BITS - 1)) begin
                  cnt   <= '0;
                  state <= S_LEN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_LEN: begin
               remain_q <= len_shift;
               if (cnt == CW'(LEN_BITS - 1)) begin
                  cnt <= '0;
                  if (len_shift == '0) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (remain_q != '0)
                  remain_q <= remain_q - 1'b1;
`ifdef PORT_DEMUX_PARITY_EN
               par_acc <= par_acc ^ bus.serIn;
               if (remain_q <= LEN_BITS'(1))
                  state <= S_PAR;
`else
               if (remain_q <= LEN_BITS'(1)) begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
               end
`endif
            end
`ifdef PORT_DEMUX_PARITY_EN
            S_PAR: begin
               perr_q <= par_acc ^ bus.serIn;
               state  <= S_DONE;
               done_q <= 1'b1;
            end
`endif
            S_DONE: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   // Payload is routed combinationally so the first bit leaves in the cycle it arrives
   always_comb begin
      bus.pval = '0;
      if (state == S_DATA)
         bus.pval[port_q] = 1'b1;
      bus.pout = bus.pval & {NUM_PORTS{bus.serIn}};
   end

   assign bus.portNum = port_q;
   assign bus.remain  = remain_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
`ifdef PORT_DEMUX_PARITY_EN
   assign bus.perr    = perr_q;
`else
   assign bus.perr    = 1'b0;
`endif
endmodule

// File: tb/tb_port_demux_ser.sv
// tb/tb_port_demux_ser.sv - self-checking bench for port_demux_ser
// Frame-level reference model, directed frame table, random frames, mid-DATA reset.
module tb_port_demux_ser;
   localparam int NP = 4;
   localparam int PB = 2;
   localparam int LB = 4;
`ifdef PORT_DEMUX_PARITY_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   typedef struct packed {
      logic [NP-1:0] pout;
      logic [NP-1:0] pval;
      logic [PB-1:0] portn;
      logic [LB-1:0] remain;
      logic          busy;
      logic          done;
      logic          perr;
   } obs_t;

   typedef struct {
      int   port;
      int   len;
      int   data;
      logic parbit;
      int   div;
      int   exp_pval_clks;
      logic exp_perr;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   port_demux_ser_if #(.NUM_PORTS(NP), .PORT_BITS(PB), .LEN_BITS(LB)) bus ();
   port_demux_ser #(.NUM_PORTS(NP), .PORT_BITS(PB), .LEN_BITS(LB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   vectors = 0;
   int   miscompares = 0;
   int   m_port = 0;
   logic m_perr = 1'b0;
   int   pval_clks;
   logic done_perr;

   function automatic obs_t sample();
      obs_t o;
      o.pout   = bus.pout;
      o.pval   = bus.pval;
      o.portn  = bus.portNum;
      o.remain = bus.remain;
      o.busy   = bus.busy;
      o.done   = bus.done;
      o.perr   = bus.perr;
      return o;
   endfunction

   task automatic check(input obs_t e, input string nm);
      obs_t a;
      a = sample();
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got pout=%b pval=%b port=%0d remain=%0d busy=%b done=%b perr=%b, want pout=%b pval=%b port=%0d remain=%0d busy=%b done=%b perr=%b",
                  nm, a.pout, a.pval, a.portn, a.remain, a.busy, a.done, a.perr,
                  e.pout, e.pval, e.portn, e.remain, e.busy, e.done, e.perr);
      end
   endtask

   task automatic check_val(input int act, input int exp, input string nm);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // One serial bit held for div clocks, clkEn only on the last; outputs must be stable throughout
   task automatic drive(input logic s, input int div, input obs_t e, input string nm);
      for (int c = 0; c < div; c++) begin
         @(negedge clk);
         bus.serIn = s;
         bus.clkEn = (c == div - 1);
         #1;
         if (bus.pval != '0) pval_clks++;
         if (bus.done) done_perr = bus.perr;
         check(e, $sformatf("%s clk%0d", nm, c));
      end
   endtask

   task automatic idle_bit(input int div, input string nm);
      obs_t e;
      e = '0;
      e.portn = PB'(m_port);
      e.perr  = m_perr;
      drive(1'b1, div, e, nm);
   endtask

   task automatic send_frame(input int port, input int len, input int data,
                             input logic parbit, input int div, input string nm);
      obs_t e;
      int   old;
      logic b;
      logic xr;
      old       = m_port;
      pval_clks = 0;
      done_perr = 1'bx;
      e = '0;
      e.portn = PB'(old);
      e.perr  = m_perr;
      drive(1'b0, div, e, {nm, " start"});
      for (int k = 0; k < PB; k++) begin
         e = '0;
         e.busy  = 1'b1;
         e.portn = PB'((((old << PB) | port) >> (PB - k)) & ((1 << PB) - 1));
         b = 1'((port >> (PB - 1 - k)) & 1);
         drive(b, div, e, $sformatf("%s port%0d", nm, k));
      end
      for (int k = 0; k < LB; k++) begin
         e = '0;
         e.busy   = 1'b1;
         e.portn  = PB'(port);
         e.remain = LB'(len >> (LB - k));
         b = 1'((len >> (LB - 1 - k)) & 1);
         drive(b, div, e, $sformatf("%s len%0d", nm, k));
      end
      xr = 1'b0;
      for (int i = 0; i < len; i++) begin
         b  = 1'((data >> (len - 1 - i)) & 1);
         xr = xr ^ b;
         e = '0;
         e.busy   = 1'b1;
         e.portn  = PB'(port);
         e.remain = LB'(len - i);
         e.pval   = NP'(1 << port);
         e.pout   = b ? e.pval : '0;
         drive(b, div, e, $sformatf("%s data%0d", nm, i));
      end
      m_perr = 1'b0;
`ifdef PORT_DEMUX_PARITY_EN
      if (len > 0) begin
         e = '0;
         e.busy  = 1'b1;
         e.portn = PB'(port);
         drive(parbit, div, e, {nm, " par"});
         m_perr = xr ^ parbit;
      end
`endif
      e = '0;
      e.busy  = 1'b1;
      e.done  = 1'b1;
      e.portn = PB'(port);
      e.perr  = m_perr;
      drive(1'($urandom_range(0, 1)), div, e, {nm, " done"});
      m_port = port;
      idle_bit(div, {nm, " idle"});
   endtask

   vec_t tbl [6];
   logic rbits [9];

   initial begin
      bus.serIn = 1'b1;
      bus.clkEn = 1'b0;
      rst = 1'b0;
      #1;
      check('0, "reset");
      repeat (3) @(negedge clk);
      rst = 1'b1;

      tbl[0] = '{port: 2, len: 3,  data: 5,      parbit: 1'b1, div: 1, exp_pval_clks: 3,  exp_perr: PAR_ON};
      tbl[1] = '{port: 2, len: 3,  data: 5,      parbit: 1'b0, div: 1, exp_pval_clks: 3,  exp_perr: 1'b0};
      tbl[2] = '{port: 1, len: 2,  data: 2,      parbit: 1'b1, div: 4, exp_pval_clks: 8,  exp_perr: 1'b0};
      tbl[3] = '{port: 3, len: 0,  data: 0,      parbit: 1'b0, div: 1, exp_pval_clks: 0,  exp_perr: 1'b0};
      tbl[4] = '{port: 0, len: 15, data: 'h5A5A, parbit: 1'b0, div: 1, exp_pval_clks: 15, exp_perr: 1'b0};
      tbl[5] = '{port: 1, len: 1,  data: 1,      parbit: 1'b0, div: 2, exp_pval_clks: 2,  exp_perr: PAR_ON};

      for (int t = 0; t < 6; t++) begin
         idle_bit(1, $sformatf("tbl%0d pre", t));
         send_frame(tbl[t].port, tbl[t].len, tbl[t].data, tbl[t].parbit, tbl[t].div,
                    $sformatf("tbl%0d", t));
         check_val(pval_clks, tbl[t].exp_pval_clks, $sformatf("tbl%0d pval_clks", t));
         check_val(int'(done_perr === 1'b1), int'(tbl[t].exp_perr), $sformatf("tbl%0d done_perr", t));
      end

      // Reset asserted in the middle of a DATA phase: port 1, length 5
      rbits = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bus.serIn = rbits[i];
         bus.clkEn = 1'b1;
      end
      #1;
      check_val(int'(bus.pval), 2, "rst pre pval");
      check_val(int'(bus.remain), 4, "rst pre remain");
      rst = 1'b0;
      #1;
      check('0, "rst mid-data");
      @(negedge clk);
      bus.serIn = 1'b1;
      bus.clkEn = 1'b0;
      rst = 1'b1;
      m_port = 0;
      m_perr = 1'b0;

      for (int f = 0; f < 40; f++) begin
         int len;
         int gap;
         len = $urandom_range(0, 15);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) idle_bit(1, $sformatf("rnd%0d gap", f));
         send_frame($urandom_range(0, NP - 1), len, int'($urandom & ((1 << len) - 1)),
                    1'($urandom_range(0, 1)), $urandom_range(1, 3), $sformatf("rnd%0d", f));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
